// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: eight-function bitwise unit behind an elastic valid/ready pipeline.
// Define BITLOGIC_PIPE_FLAGS_EN to add the y_zero / y_parity result flags.

module bitwise_logic_stage #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    output logic          valid,
    output logic [PW-1:0] data
);
    // Payload only moves with a real transaction, so y stays quiet across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) data <= up_data;
        end
    end
endmodule

module bitwise_logic_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef BITLOGIC_PIPE_FLAGS_EN
    output logic             y_zero,
    output logic             y_parity,
`endif
    output logic [CNT_W-1:0] done_cnt
);
`ifdef BITLOGIC_PIPE_FLAGS_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH;
`endif

    logic [WIDTH-1:0]          f;
    logic [PW-1:0]             payload;
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0]           rdy;
    logic [STAGES:0][PW-1:0]   dat_pipe;

    always_comb begin
        f = a;
        case (op)
            3'b000:  f = ~a;
            3'b001:  f = a & b;
            3'b010:  f = a | b;
            3'b011:  f = a ^ b;
            3'b100:  f = ~(a & b);
            3'b101:  f = ~(a | b);
            3'b110:  f = ~(a ^ b);
            default: f = a;
        endcase
    end

`ifdef BITLOGIC_PIPE_FLAGS_EN
    // Flags ride in the top two payload bits: {zero, parity, result}.
    assign payload = {~|f, ^f, f};
`else
    assign payload = f;
`endif

    // Index 0 is the producer side, index STAGES is the consumer side.
    assign vld_pipe[0]  = in_valid;
    assign dat_pipe[0]  = payload;
    assign rdy[STAGES]  = out_ready;
    assign in_ready     = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign rdy[i] = !vld_pipe[i+1] | rdy[i+1];

        bitwise_logic_stage #(.PW(PW)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .load     (rdy[i]),
            .up_valid (vld_pipe[i]),
            .up_data  (dat_pipe[i]),
            .valid    (vld_pipe[i+1]),
            .data     (dat_pipe[i+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign y         = dat_pipe[STAGES][WIDTH-1:0];
`ifdef BITLOGIC_PIPE_FLAGS_EN
    assign y_zero    = dat_pipe[STAGES][WIDTH+1];
    assign y_parity  = dat_pipe[STAGES][WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (reset)
            done_cnt <= '0;
        else if (out_valid && out_ready && (done_cnt != {CNT_W{1'b1}}))
            done_cnt <= done_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe; a second instance with CNT_W=2 checks saturation.
// Build with BITLOGIC_PIPE_FLAGS_EN defined to also check the result flags.

module tb_bitwise_logic_pipe;
    localparam int W = 4;
    localparam int S = 2;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, y, y2;
    logic         in_ready, out_valid, in_ready2, out_valid2;
    logic [C-1:0] done_cnt;
    logic [1:0]   done_cnt2;
`ifdef BITLOGIC_PIPE_FLAGS_EN
    logic         y_zero, y_parity, y_zero2, y_parity2;
`endif

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(C)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y),
`ifdef BITLOGIC_PIPE_FLAGS_EN
        .y_zero(y_zero), .y_parity(y_parity),
`endif
        .done_cnt(done_cnt)
    );

    bitwise_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2),
`ifdef BITLOGIC_PIPE_FLAGS_EN
        .y_zero(y_zero2), .y_parity(y_parity2),
`endif
        .done_cnt(done_cnt2)
    );

    int           n_chk = 0;
    int           n_err = 0;
    int           exp_cnt = 0;
    int           exp_cnt2 = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fn(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        case (o)
            3'b000:  return ~x;
            3'b001:  return x & z;
            3'b010:  return x | z;
            3'b011:  return x ^ z;
            3'b100:  return ~(x & z);
            3'b101:  return ~(x | z);
            3'b110:  return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    // Inputs change just after posedge, so the negedge view predicts the next edge's transfers.
    always @(negedge clk) begin
        logic [W-1:0] e;
        chk("done_cnt", done_cnt, exp_cnt);
        chk("done_cnt2", done_cnt2, exp_cnt2);
        if (reset) begin
            exp_q.delete();
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", y, e);
                    chk("y2", y2, e);
`ifdef BITLOGIC_PIPE_FLAGS_EN
                    chk("y_zero", y_zero, e == '0);
                    chk("y_parity", y_parity, ^e);
`endif
                end
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            if (in_valid && in_ready) exp_q.push_back(fn(op, a, b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_timeout", out_valid, 1);
    endtask

    task automatic push(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        in_valid = 1'b1; op = o; a = x; b = z;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [W-1:0] sweep_tbl [8];
    logic [W-1:0] first_y;

    initial begin
        sweep_tbl = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        step();
        step();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_in_ready", in_ready, 1);
        step();

        // single inversion, two-cycle latency
        push(3'b000, 4'b1010, 4'b0000);
        @(negedge clk); chk("lat_early", out_valid, 0);
        @(negedge clk); chk("lat_valid", out_valid, 1); chk("inv_y", y, 4'b0101);
        @(negedge clk); chk("inv_cnt", done_cnt, 1);
        step();

        // back-to-back op sweep
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'(i); a = 4'b1100; b = 4'b1010;
            @(negedge clk);
            chk("sweep_in_ready", in_ready, 1);
            if (i >= S) begin
                chk("sweep_valid", out_valid, 1);
                chk("sweep_y", y, sweep_tbl[i-S]);
            end
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < S; k++) begin
            @(negedge clk);
            chk("sweep_tail_valid", out_valid, 1);
            chk("sweep_tail_y", y, sweep_tbl[8-S+k]);
            step();
        end
        repeat (2) step();

        // stall: two accepted, third refused, head held stable
        out_ready = 1'b0;
        first_y = fn(3'b011, 4'b0001, 4'b0111);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; op = 3'b011; a = 4'(k + 1); b = 4'b0111;
            @(negedge clk);
            chk("stall_in_ready", in_ready, (k < 2) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_y", y, first_y);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();
        chk("stall_drained", exp_q.size(), 0);

        // full pipe: accept and emit in the same cycle
        out_ready = 1'b0;
        push(3'b010, 4'b0001, 4'b0010);
        push(3'b100, 4'b1111, 4'b0110);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'b111; a = 4'b1001;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1);
        chk("full_out_valid", out_valid, 1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("full_still_full", in_ready, 0);
        chk("full_occ_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        repeat (4) step();
        chk("full_drained", exp_q.size(), 0);

        // reset with two results in flight
        out_ready = 1'b0;
        push(3'b001, 4'b1111, 4'b1010);
        push(3'b110, 4'b0011, 4'b0101);
        do_reset();
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_cnt", done_cnt, 0);
        step();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_out", out_valid, 0);
            step();
        end

        // CNT_W=2 saturation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push(3'b101, 4'(k), 4'b0100);
            wait_out();
            step();
            @(negedge clk);
            chk("cnt2_sat", done_cnt2, (k < 3) ? k + 1 : 3);
            step();
        end

`ifdef BITLOGIC_PIPE_FLAGS_EN
        push(3'b001, 4'b0101, 4'b1010);
        wait_out();
        chk("flag_y", y, 0);
        chk("flag_zero", y_zero, 1);
        chk("flag_parity", y_parity, 0);
        step();
`endif
        repeat (3) step();
        chk("final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
